usart_tx: RTL
=============

Name: usart_tx

Overview:
Serial transmitter that pairs with usart_rx. It accepts bytes from the system side over a valid/ready handshake and buffers them in a small FIFO. Each byte goes out on tx_pin as an 8N1 frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Frame starts are gated by active-low cts_pin, which connects to the far end's rts_pin. It sits beside usart_rx inside the USART peripheral and is clocked by comm_clock only.

Parameters:
FIFO_DEPTH, 4, number of buffered bytes; power of two, minimum 2.
USE_CTS, 1, 1 = cts_pin gates frame starts; 0 = cts_pin ignored.

Ports:
comm_clock  input  1  single clock for all logic.
reset  input  1  synchronous, active-high.
clocks_per_bit  input  12  bit period minus one, in comm_clock cycles.
data_in  input  8  byte to transmit.
valid  input  1  data_in is valid.
ready  output  1  FIFO can accept a byte.
busy  output  1  frame in progress or FIFO non-empty.
tx_pin  output  1  serial line; idle high.
cts_pin  input  1  clear-to-send, active low, asynchronous.

Behaviour:
- Reset (sampled on the comm_clock edge):
  - tx_pin=1, ready=0 during reset, busy=0.
  - FIFO emptied; FSM enters IDLE.
  - CTS synchronizer flops set to 1 (deasserted).
  - ready=1 from the first cycle after reset deasserts.
- Reset mid-frame: the frame is abandoned; tx_pin=1 on the next edge; buffered bytes are discarded.
- Handshake:
  - A byte is pushed on every edge where valid && ready.
  - ready = !full, where full is computed from the registered count. No push can occur when full, even if a pop happens in the same cycle.
  - Simultaneous push and pop: count unchanged, both take effect.
- FIFO: circular buffer with log2(FIFO_DEPTH)-bit pointers that wrap naturally. The count is one bit wider than the pointers.
- CTS: passed through a 2-flop synchronizer, giving 2 cycles of latency. cts_ok = !cts_sync when USE_CTS=1, else 1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_pin=1. When the FIFO is non-empty and cts_ok, on that edge:
    - pop the head byte into shift[7:0];
    - latch clocks_per_bit into bit_len;
    - clear bit_cnt and bit_idx;
    - go to START.
  - START: tx_pin=0 for bit_len+1 cycles, then go to DATA.
  - DATA: tx_pin=shift[0]. Each bit lasts bit_len+1 cycles. At the end of each bit: shift right and increment bit_idx. After bit_idx 7 completes, go to STOP.
  - STOP: tx_pin=1 for bit_len+1 cycles, then go to IDLE.
- Bit timing: bit_cnt counts 0..bit_len. A bit ends on the cycle where bit_cnt==bit_len. clocks_per_bit=0 gives 1 cycle per bit.
- clocks_per_bit changes mid-frame have no effect until the next frame.
- tx_pin is registered.
  - Latency: a byte pushed at edge E into an empty FIFO, with cts_ok already true, drives tx_pin=0 from edge E+1.
  - Frame length is exactly 10*(bit_len+1) cycles.
- Back-to-back: when STOP ends and the FIFO is non-empty, the FSM passes through IDLE for exactly 1 cycle (tx_pin=1), then starts the next frame. The minimum gap is one cycle of extra stop level.
- cts_ok going false mid-frame: the current frame completes; no new frame starts until cts_ok is true again.
- busy = (state != IDLE) || (count != 0).

Test Plan:
- Single byte, clocks_per_bit=3, cts_pin=0: push 0x75 → after 1 edge, tx_pin runs 0,1,0,1,0,1,1,1,0,1, each level held 4 cycles. busy is high for 40 cycles, then tx_pin=1 and busy=0.
- Loopback with usart_rx at a matching bit rate: push 0x75 then 0xF5 → receiver reports valid with data_out=0x75, then 0xF5, error=0. The two frames are separated by exactly 1 extra idle cycle.
- FIFO full, FIFO_DEPTH=4, cts_pin=1: push 5 bytes while holding valid → ready drops after 4 accepts, the 5th is held. Release cts_pin=0 → the first frame starts 3 cycles later, ready rises one cycle after the first pop, and the 5th byte is accepted.
- CTS mid-frame: raise cts_pin during the data bits of frame 1 with 2 bytes queued → frame 1 completes intact and tx_pin stays 1. Lower cts_pin → frame 2 starts 3 cycles later.
- Reset mid-frame: assert reset during bit 3 with 2 bytes queued → tx_pin=1 next edge, busy=0, ready=1 one cycle after release, and no further frames are sent.
- clocks_per_bit=0: push 0xA5 → 10-cycle frame: 0,1,0,1,0,0,1,0,1,1. Changing clocks_per_bit to 7 mid-frame does not alter that frame's timing.

Source files
------------

// File: rtl/usart_tx.sv
// usart_tx
// Serial 8N1 transmitter for the USART peripheral, clocked by comm_clock only.
// Bytes arrive on a valid/ready handshake and wait in a small circular FIFO.
// Each byte leaves on tx_pin as one start bit (0), eight data bits LSB first
// and one stop bit (1). New frames only start while the far end's active-low
// clear-to-send (cts_pin) is asserted, unless USE_CTS is 0.
//
// Ports:
//   comm_clock     - single clock for all logic
//   reset          - synchronous, active-high
//   clocks_per_bit - bit period minus one, in comm_clock cycles
//   data_in        - byte to transmit
//   valid          - data_in is valid
//   ready          - FIFO can accept a byte
//   busy           - frame in progress or FIFO non-empty
//   tx_pin         - registered serial line, idle high
//   cts_pin        - clear-to-send, active low, asynchronous to comm_clock
module usart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter bit USE_CTS    = 1'b1
) (
  input  logic        comm_clock,
  input  logic        reset,
  input  logic [11:0] clocks_per_bit,
  input  logic [7:0]  data_in,
  input  logic        valid,
  output logic        ready,
  output logic        busy,
  output logic        tx_pin,
  input  logic        cts_pin
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             cts_meta_q;
  logic             cts_sync_q;
  logic             cts_ok;

  state_e           state_q;
  logic [11:0]      bit_len_q;
  logic [11:0]      bit_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             bit_end;

  // Full is taken from the registered count only, so a pop in the same cycle
  // never opens room for a push. Ready is held low while reset is asserted.
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign ready   = !reset && !full;
  assign push    = valid && ready;
  assign cts_ok  = USE_CTS ? !cts_sync_q : 1'b1;
  assign pop     = (state_q == IDLE) && !empty && cts_ok;
  assign bit_end = (bit_cnt_q == bit_len_q);
  assign busy    = (state_q != IDLE) || !empty;
  assign tx_pin  = tx_q;

  // Two-flop synchronizer for the asynchronous cts_pin; resets to the
  // deasserted (high) level so nothing starts until CTS is seen low.
  always_ff @(posedge comm_clock) begin
    if (reset) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts_pin;
      cts_sync_q <= cts_meta_q;
    end
  end

  // FIFO storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge comm_clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; the count is one bit
  // wider so that full and empty are distinguishable.
  always_ff @(posedge comm_clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Frame FSM. tx_q is loaded with the level of the state being entered, so
  // the line changes on the same edge as the state. bit_len is captured at
  // frame start, so clocks_per_bit changes only affect the next frame.
  always_ff @(posedge comm_clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_len_q <= '0;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q   <= mem_q[rd_ptr_q];
            bit_len_q <= clocks_per_bit;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            state_q   <= START;
            tx_q      <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            state_q   <= DATA;
            tx_q      <= shift_q[0];
          end else begin
            bit_cnt_q <= bit_cnt_q + 12'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_q    <= shift_q[1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 12'd1;
          end
        end
        STOP: begin
          // Returning through IDLE gives one extra stop-level cycle between
          // back-to-back frames.
          if (bit_end) begin
            bit_cnt_q <= '0;
            state_q   <= IDLE;
            tx_q      <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + 12'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
